// File: rtl/elevator_request_queue_if.sv
// Signal bundle between the request queue and the board/controller side.
// The controller side (master) drives the raw buttons and cab status; the queue (slave) returns requests and target.
interface elevator_request_queue_if #(
  parameter int FLOORS = 4
);
  logic [FLOORS-1:0] KEY_N;
  logic [FLOORS-1:0] CALL;
  logic [1:0]        cur_floor;
  logic              moving;
  logic              door_open;
  logic [FLOORS-1:0] pending;
  logic [1:0]        target;
  logic              target_valid;
  logic              dir_up;

  modport master (
    output KEY_N, CALL, cur_floor, moving, door_open,
    input  pending, target, target_valid, dir_up
  );

  modport slave (
    input  KEY_N, CALL, cur_floor, moving, door_open,
    output pending, target, target_valid, dir_up
  );
endinterface

// File: rtl/elevator_request_queue.sv
// Request stage for the elevator FSM: synchronizes cabin buttons and hall
// calls, latches one request per floor and picks the next target by SCAN sweep.
module elevator_request_queue #(
  parameter int FLOORS     = 4,
  parameter int LOCKOUT_CY = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  elevator_request_queue_if.slave bus
);
  localparam int IDX_W = 2;
  localparam int CNT_W = $clog2(LOCKOUT_CY + 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CY);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [FLOORS-1:0] key_s1_q, key_s2_q, key_prev_q;
  logic [FLOORS-1:0] call_s1_q, call_s2_q, call_prev_q;

  logic [CNT_W-1:0] key_cnt_q  [FLOORS];
  logic [CNT_W-1:0] key_cnt_d  [FLOORS];
  logic [CNT_W-1:0] call_cnt_q [FLOORS];
  logic [CNT_W-1:0] call_cnt_d [FLOORS];

  logic [FLOORS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]  target_q, target_d;
  logic              target_valid_q, target_valid_d;
  logic              dir_up_q, dir_up_d;

  logic [FLOORS-1:0] key_acc, call_acc, set_mask, clr_mask;
  logic [FLOORS-1:0] above, below;
  logic              here;
  logic [IDX_W-1:0]  low_above, high_below;

  // Sync chains reset to the released level so a press held through reset shows up as a fresh edge.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_s1_q    <= '1;
      key_s2_q    <= '1;
      key_prev_q  <= '1;
      call_s1_q   <= '0;
      call_s2_q   <= '0;
      call_prev_q <= '0;
    end else begin
      key_s1_q    <= bus.KEY_N;
      key_s2_q    <= key_s1_q;
      key_prev_q  <= key_s2_q;
      call_s1_q   <= bus.CALL;
      call_s2_q   <= call_s1_q;
      call_prev_q <= call_s2_q;
    end
  end

  always_comb begin
    key_acc  = '0;
    call_acc = '0;
    for (int f = 0; f < FLOORS; f++) begin
      key_cnt_d[f]  = key_cnt_q[f];
      call_cnt_d[f] = call_cnt_q[f];
      if (key_prev_q[f] && !key_s2_q[f] && (key_cnt_q[f] == '0)) begin
        key_acc[f]   = 1'b1;
        key_cnt_d[f] = LOCK_LOAD;
      end else if (key_cnt_q[f] != '0) begin
        key_cnt_d[f] = key_cnt_q[f] - CNT_ONE;
      end
      if (!call_prev_q[f] && call_s2_q[f] && (call_cnt_q[f] == '0)) begin
        call_acc[f]   = 1'b1;
        call_cnt_d[f] = LOCK_LOAD;
      end else if (call_cnt_q[f] != '0) begin
        call_cnt_d[f] = call_cnt_q[f] - CNT_ONE;
      end
    end
  end

  // A clear on the served floor beats a simultaneous new press there.
  always_comb begin
    set_mask  = key_acc | call_acc;
    clr_mask  = bus.door_open ? (FLOORS'(1) << bus.cur_floor) : '0;
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_comb begin
    above = '0;
    below = '0;
    for (int f = 0; f < FLOORS; f++) begin
      if (IDX_W'(f) > bus.cur_floor) above[f] = pending_q[f];
      if (IDX_W'(f) < bus.cur_floor) below[f] = pending_q[f];
    end
    here = pending_q[bus.cur_floor];

    low_above = '0;
    for (int f = FLOORS - 1; f >= 0; f--) begin
      if (above[f]) low_above = IDX_W'(f);
    end
    high_below = '0;
    for (int f = 0; f < FLOORS; f++) begin
      if (below[f]) high_below = IDX_W'(f);
    end
  end

  // Nearest stop ahead in the sweep direction, else nearest behind, else hold.
  always_comb begin
    target_d       = target_q;
    target_valid_d = |pending_q;
    dir_up_d       = dir_up_q;

    if (here && !bus.moving) begin
      target_d = bus.cur_floor;
    end else if (dir_up_q) begin
      if (|above)      target_d = low_above;
      else if (|below) target_d = high_below;
    end else begin
      if (|below)      target_d = high_below;
      else if (|above) target_d = low_above;
    end

    if (!bus.moving && !bus.door_open) begin
      if (dir_up_q && (above == '0) && (below != '0)) begin
        dir_up_d = 1'b0;
      end else if (!dir_up_q && (below == '0) && (above != '0)) begin
        dir_up_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int f = 0; f < FLOORS; f++) begin
        key_cnt_q[f]  <= '0;
        call_cnt_q[f] <= '0;
      end
      pending_q      <= '0;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      dir_up_q       <= 1'b1;
    end else begin
      for (int f = 0; f < FLOORS; f++) begin
        key_cnt_q[f]  <= key_cnt_d[f];
        call_cnt_q[f] <= call_cnt_d[f];
      end
      pending_q      <= pending_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      dir_up_q       <= dir_up_d;
    end
  end

  assign bus.pending      = pending_q;
  assign bus.target       = target_q;
  assign bus.target_valid = target_valid_q;
  assign bus.dir_up       = dir_up_q;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed bench for elevator_request_queue: each scenario task drives the
// buttons/cab status and compares outputs against hand-derived values.
module tb_elevator_request_queue;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  elevator_request_queue_if #(.FLOORS(4)) bus ();

  elevator_request_queue #(.FLOORS(4), .LOCKOUT_CY(4)) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge, inputs change there too.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.KEY_N = '1; bus.CALL = '0; bus.cur_floor = 2'd0;
    bus.moving = 1'b0; bus.door_open = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL rst_pending got=%b want=0000", bus.pending); end
    total++; if (bus.target !== 2'd0) begin bad++; $display("FAIL rst_target got=%0d want=0", bus.target); end
    total++; if (bus.target_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.target_valid); end
    total++; if (bus.dir_up !== 1'b1) begin bad++; $display("FAIL rst_dir got=%b want=1", bus.dir_up); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick(4);
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL rst_idle_pending got=%b want=0000", bus.pending); end
  endtask

  task automatic test_simultaneous();
    bus.KEY_N[2] = 1'b0; bus.CALL[1] = 1'b1;
    tick(1);
    bus.KEY_N[2] = 1'b1; bus.CALL[1] = 1'b0;
    tick(1);
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL sim_early got=%b want=0000", bus.pending); end
    tick(1);
    total++; if (bus.pending !== 4'b0110) begin bad++; $display("FAIL sim_pending got=%b want=0110", bus.pending); end
    total++; if (bus.target_valid !== 1'b0) begin bad++; $display("FAIL sim_valid_early got=%b want=0", bus.target_valid); end
    tick(1);
    total++; if (bus.target !== 2'd1) begin bad++; $display("FAIL sim_target got=%0d want=1", bus.target); end
    total++; if (bus.target_valid !== 1'b1) begin bad++; $display("FAIL sim_valid got=%b want=1", bus.target_valid); end
    total++; if (bus.dir_up !== 1'b1) begin bad++; $display("FAIL sim_dir got=%b want=1", bus.dir_up); end
  endtask

  task automatic test_service_clear();
    bus.cur_floor = 2'd1; bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0;
    total++; if (bus.pending !== 4'b0100) begin bad++; $display("FAIL svc_pending got=%b want=0100", bus.pending); end
    tick(1);
    total++; if (bus.target !== 2'd2) begin bad++; $display("FAIL svc_target got=%0d want=2", bus.target); end
    tick(3);
    bus.door_open = 1'b1; bus.CALL[1] = 1'b1;
    tick(1);
    bus.CALL[1] = 1'b0;
    tick(3);
    total++; if (bus.pending !== 4'b0100) begin bad++; $display("FAIL svc_clear_wins got=%b want=0100", bus.pending); end
    bus.door_open = 1'b0;
    tick(2);
    total++; if (bus.pending !== 4'b0100) begin bad++; $display("FAIL svc_after_door got=%b want=0100", bus.pending); end
    total++; if (bus.target !== 2'd2) begin bad++; $display("FAIL svc_target_hold got=%0d want=2", bus.target); end
  endtask

  task automatic test_reversal();
    bus.cur_floor = 2'd2; bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0; bus.moving = 1'b1; bus.cur_floor = 2'd3;
    bus.KEY_N[3] = 1'b0; bus.CALL[0] = 1'b1;
    tick(1);
    bus.KEY_N[3] = 1'b1; bus.CALL[0] = 1'b0;
    tick(2);
    total++; if (bus.pending !== 4'b1001) begin bad++; $display("FAIL rev_pending got=%b want=1001", bus.pending); end
    tick(1);
    total++; if (bus.target !== 2'd0) begin bad++; $display("FAIL rev_moving_target got=%0d want=0", bus.target); end
    tick(3);
    total++; if (bus.dir_up !== 1'b1) begin bad++; $display("FAIL rev_moving_dir got=%b want=1", bus.dir_up); end
    bus.moving = 1'b0; bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0;
    total++; if (bus.pending !== 4'b0001) begin bad++; $display("FAIL rev_cleared got=%b want=0001", bus.pending); end
    total++; if (bus.target !== 2'd3) begin bad++; $display("FAIL rev_here_target got=%0d want=3", bus.target); end
    total++; if (bus.dir_up !== 1'b1) begin bad++; $display("FAIL rev_door_dir got=%b want=1", bus.dir_up); end
    tick(1);
    total++; if (bus.dir_up !== 1'b0) begin bad++; $display("FAIL rev_dir got=%b want=0", bus.dir_up); end
    total++; if (bus.target !== 2'd0) begin bad++; $display("FAIL rev_target got=%0d want=0", bus.target); end
  endtask

  task automatic test_mid_move();
    bus.cur_floor = 2'd0; bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0;
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL mid_empty got=%b want=0000", bus.pending); end
    tick(1);
    total++; if (bus.target_valid !== 1'b0) begin bad++; $display("FAIL mid_valid_low got=%b want=0", bus.target_valid); end
    total++; if (bus.dir_up !== 1'b0) begin bad++; $display("FAIL mid_dir_hold got=%b want=0", bus.dir_up); end
    bus.KEY_N[3] = 1'b0;
    tick(1);
    bus.KEY_N[3] = 1'b1;
    tick(2);
    total++; if (bus.pending !== 4'b1000) begin bad++; $display("FAIL mid_pending3 got=%b want=1000", bus.pending); end
    tick(1);
    total++; if (bus.dir_up !== 1'b1) begin bad++; $display("FAIL mid_floor0_dir got=%b want=1", bus.dir_up); end
    total++; if (bus.target !== 2'd3) begin bad++; $display("FAIL mid_target3 got=%0d want=3", bus.target); end
    bus.moving = 1'b1; bus.CALL[1] = 1'b1;
    tick(1);
    bus.CALL[1] = 1'b0;
    tick(2);
    total++; if (bus.pending !== 4'b1010) begin bad++; $display("FAIL mid_pending got=%b want=1010", bus.pending); end
    tick(1);
    total++; if (bus.target !== 2'd1) begin bad++; $display("FAIL mid_insert got=%0d want=1", bus.target); end
    total++; if (bus.dir_up !== 1'b1) begin bad++; $display("FAIL mid_insert_dir got=%b want=1", bus.dir_up); end
    bus.cur_floor = 2'd1; bus.moving = 1'b0; bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0;
    total++; if (bus.pending !== 4'b1000) begin bad++; $display("FAIL mid_served got=%b want=1000", bus.pending); end
    tick(1);
    total++; if (bus.target !== 2'd3) begin bad++; $display("FAIL mid_resume got=%0d want=3", bus.target); end
  endtask

  task automatic test_lockout();
    bus.cur_floor = 2'd3; bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0;
    tick(6);
    bus.KEY_N[3] = 1'b0; tick(1);
    bus.KEY_N[3] = 1'b1; tick(1);
    bus.KEY_N[3] = 1'b0; tick(1);
    bus.KEY_N[3] = 1'b1;
    total++; if (bus.pending !== 4'b1000) begin bad++; $display("FAIL lock_first got=%b want=1000", bus.pending); end
    bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0;
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL lock_cleared got=%b want=0000", bus.pending); end
    tick(1);
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL lock_bounce got=%b want=0000", bus.pending); end
    tick(3);
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL lock_bounce_late got=%b want=0000", bus.pending); end
    tick(6);
    bus.KEY_N[3] = 1'b0; tick(1);
    bus.KEY_N[3] = 1'b1; tick(2);
    total++; if (bus.pending !== 4'b1000) begin bad++; $display("FAIL lock_press_a got=%b want=1000", bus.pending); end
    bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0;
    tick(2);
    bus.KEY_N[3] = 1'b0; tick(1);
    bus.KEY_N[3] = 1'b1; tick(1);
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL lock_spaced_early got=%b want=0000", bus.pending); end
    tick(1);
    total++; if (bus.pending !== 4'b1000) begin bad++; $display("FAIL lock_spaced got=%b want=1000", bus.pending); end
  endtask

  task automatic test_all_floors_reset();
    bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0; bus.cur_floor = 2'd0;
    tick(1);
    bus.CALL = 4'b1111;
    tick(1);
    bus.CALL = 4'b0000;
    tick(2);
    total++; if (bus.pending !== 4'b1111) begin bad++; $display("FAIL all_pending got=%b want=1111", bus.pending); end
    tick(1);
    total++; if (bus.target !== 2'd0) begin bad++; $display("FAIL all_t0 got=%0d want=0", bus.target); end
    for (int f = 0; f < 2; f++) begin
      bus.door_open = 1'b1;
      tick(1);
      bus.door_open = 1'b0;
      tick(1);
      total++; if (bus.target !== 2'(f + 1)) begin bad++; $display("FAIL all_sweep got=%0d want=%0d", bus.target, f + 1); end
      bus.cur_floor = 2'(f + 1);
    end
    total++; if (bus.pending !== 4'b1100) begin bad++; $display("FAIL all_mid_pending got=%b want=1100", bus.pending); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL async_pending got=%b want=0000", bus.pending); end
    total++; if (bus.target !== 2'd0) begin bad++; $display("FAIL async_target got=%0d want=0", bus.target); end
    total++; if (bus.target_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", bus.target_valid); end
    total++; if (bus.dir_up !== 1'b1) begin bad++; $display("FAIL async_dir got=%b want=1", bus.dir_up); end
    bus.CALL[2] = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL held_early got=%b want=0000", bus.pending); end
    tick(1);
    total++; if (bus.pending !== 4'b0100) begin bad++; $display("FAIL held_press got=%b want=0100", bus.pending); end
    bus.CALL[2] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_service_clear();
    test_reversal();
    test_mid_move();
    test_lockout();
    test_all_floors_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/elevator_request_queue.md
# elevator_request_queue

Upstream request stage for the elevator controller FSM. It conditions the raw cabin buttons and hall-call switches, latches one pending request per floor, and clears a request when the FSM reports the door open at that floor. From the pending set, a SCAN (collective-sweep) policy selects the next target floor. The FSM consumes `target`/`target_valid`, and `pending` drives the request LEDs.

## Interface
Parameters:
- `FLOORS`, 4: number of floors; floor index 0..FLOORS-1. Only 4 is required; index width is 2.
- `LOCKOUT_CY`, 4: cycles an input is ignored after an accepted press. Counter width is clog2(LOCKOUT_CY+1).

Ports:
- `CLOCK_50`, in, 1: system clock; all state is on the rising edge.
- `RESET_N`, in, 1: asynchronous, active-low reset.
- `KEY_N`, in, FLOORS: raw cabin buttons, active-low (0 = pressed), asynchronous to the clock.
- `CALL`, in, FLOORS: raw hall-call switches, active-high, asynchronous to the clock.
- `cur_floor`, in, 2: last floor reached or passed, as reported by the FSM.
- `moving`, in, 1: cab is between floors.
- `door_open`, in, 1: door is open at `cur_floor`.
- `pending`, out, FLOORS: latched requests; bit f means floor f is requested.
- `target`, out, 2: selected destination floor.
- `target_valid`, out, 1: high when `pending` is nonzero.
- `dir_up`, out, 1: current sweep direction; 1 = up.

## Operation
- **Conditioning:** each of the 2·FLOORS raw inputs passes through a 2-flop synchronizer. The synchronizer resets to the not-asserted value: KEY_N flops to 1, CALL flops to 0.
- **Edge detection:** a request event is a not-asserted→asserted transition at the synchronizer output. KEY_N and CALL for the same floor are ORed only after per-input edge detection.
- **Lockout:** an accepted edge loads that input's counter with LOCKOUT_CY. While the counter is nonzero, further edges on that input are ignored. The counter decrements to 0.
- **Pending set:** `pending[f]` is set by any accepted event for floor f.
- **Pending clear:** `pending[cur_floor]` is cleared in every cycle that `door_open`=1.
- **Set/clear conflict:** if a set and a clear hit the same bit in the same cycle, the clear wins, because the request is being served.
- **Floors:**
  - above = pending bits with index > `cur_floor`.
  - below = pending bits with index < `cur_floor`.
  - here = `pending[cur_floor]`.
- **Target selection** (registered every cycle):
  - If here and !moving: target = cur_floor.
  - Else if dir_up and above is nonzero: target = lowest set index in above.
  - Else if !dir_up and below is nonzero: target = highest set index in below.
  - Else if the opposite side is nonzero: target = nearest set floor on that side.
  - Else: target holds its value.
- **Direction register:** `dir_up` toggles only when all of these hold:
  - !moving and !door_open;
  - no pending floor in the current direction;
  - at least one pending floor in the opposite direction.
  
  It never toggles while moving.
- **Mid-move requests:** a new request between `cur_floor` and the old target, in the travel direction, becomes the new target on the next selection cycle. This is how intermediate stops are inserted.
- **Boundaries:**
  - At floor 0 with dir_up=0 and only above pending: dir_up→1.
  - At floor FLOORS-1: symmetric.
  - All floors requested at once: all bits set; target walks the sweep.

## Timing
- **Reset values:** pending=0, target=0, target_valid=0, dir_up=1. All counters are 0 and synchronizers are at not-asserted.
- **Reset mid-operation:** outputs go to reset values immediately and asynchronously; queued requests are discarded.
- **Input held across reset:** an input held asserted across reset release registers as one new press.
- **Press latency:** a raw input change sampled at edge 0 appears in `pending` after edge 3 (2 synchronizer edges + 1 edge-detect/latch edge). `target`/`target_valid`/`dir_up` reflect it after edge 4.
- **Clear latency:** `door_open`=1 sampled at edge n clears the bit after edge n. `target` updates after edge n+1.
- **Minimum accepted spacing:** per input, LOCKOUT_CY+1 cycles between accepted presses.
- **No handshake:** the FSM samples `target` whenever it needs it. `target` is stable while `pending` and `cur_floor` are unchanged.

## Test plan
- **Simultaneous requests:** after reset, cur_floor=0, pulse KEY_N[2]=0 and CALL[1]=1 together for 1 cycle. Expect pending=4'b0110 at +3 cycles; target=1, target_valid=1, dir_up=1 at +4.
- **Service clear:** from the previous state, cur_floor=1, door_open=1 for 1 cycle. Expect pending=4'b0100 next edge and target=2 one edge later. Also pulse CALL[1] during door_open: pending[1] stays 0.
- **Reversal:** cur_floor=3, dir_up=1, pending=4'b1001, door_open=1 then 0, moving=0. Expect pending=4'b0001, then dir_up=0 and target=0. Also hold moving=1 at the same state: dir_up does not change.
- **Mid-move insertion:** cur_floor=0, moving=1, pending=4'b1000, target=3; pulse CALL[1]. Expect target=1 at +4 with dir_up still 1. Then cur_floor=1, door_open clears bit 1, and target returns to 3.
- **Bounce/lockout:** toggle KEY_N[3] 1→0→1→0 on consecutive cycles (LOCKOUT_CY=4). Expect pending[3] set exactly once. After a clear, a press 2 cycles after the previous accepted one is ignored; a press 6 cycles after is accepted.
- **All floors + reset:** assert all CALL bits simultaneously. Expect pending=4'b1111 and targets served in sweep order 0,1,2,3. Drop RESET_N mid-sweep: pending=0 and dir_up=1 immediately, without waiting for a clock edge.
